bitty_fetch: RTL and testbench

Instruction sequencer that drives the bitty core's `run`/`done` interface from a synchronous-read instruction memory. It walks a program counter from `start_addr` to `end_addr` and presents each 16-bit word on `instruction`. It pulses `run`, then holds the word stable until the core answers with `done`. A watchdog aborts the program if the core never answers. The block sits between the program ROM/RAM and `bitty_core`, one level up in the top-level wrapper.

---
 rtl/bitty_pkg.sv | 22 ++
 rtl/register.sv | 17 +
 rtl/bitty_fetch.sv | 90 +++++++++
 tb/tb_bitty_fetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bitty_pkg.sv
// rtl/bitty_pkg.sv - shared constants and state encoding for the bitty fetch sequencer
package bitty_pkg;

  localparam int INSTR_W = 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_ISSUE     = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_HALT      = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    FETCH     = ST_FETCH,
    LOAD      = ST_LOAD,
    ISSUE     = ST_ISSUE,
    WAIT_DONE = ST_WAIT_DONE,
    HALT      = ST_HALT
  } state_t;

endpackage

// File: rtl/register.sv
// rtl/register.sv - generic enabled register with synchronous active-high reset
module register #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/bitty_fetch.sv
// rtl/bitty_fetch.sv - walks PC over instruction memory, issues run/done handshakes to bitty core
module bitty_fetch
  import bitty_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [ADDR_W-1:0]  end_addr,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] instruction,
  output logic               run,
  input  logic               done,
  output logic               busy,
  output logic               halted,
  output logic               err,
  output logic [15:0]        retired
);

  localparam int WD_W = $clog2(TIMEOUT);

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, end_pc;
  logic [WD_W-1:0]   wdog;
  logic              launch, accept, timeout, spurious;

  always_comb begin
    launch     = start && (state == IDLE || state == HALT);
    accept     = (state == WAIT_DONE) && done;
    // done wins over a coincident watchdog expiry
    timeout    = (state == WAIT_DONE) && !done && (wdog == WD_W'(TIMEOUT - 1));
    spurious   = done && (state != WAIT_DONE);
    state_next = state;
    case (state)
      IDLE, HALT: if (start) state_next = FETCH;
      FETCH:      state_next = LOAD;
      LOAD:       state_next = ISSUE;
      ISSUE:      state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (done)         state_next = (pc == end_pc) ? HALT : FETCH;
        else if (timeout) state_next = HALT;
      end
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= '0;
      end_pc  <= '0;
      wdog    <= '0;
      run     <= 1'b0;
      err     <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_next;
      run   <= (state_next == ISSUE);
      if (launch) begin
        pc      <= start_addr;
        end_pc  <= end_addr;
        retired <= '0;
      end else if (accept) begin
        retired <= retired + 16'd1;
        if (pc != end_pc) pc <= pc + 1'b1;
      end
      if (state != WAIT_DONE) wdog <= '0;
      else if (!done)         wdog <= wdog + 1'b1;
      if (timeout || spurious) err <= 1'b1;
      else if (launch)         err <= 1'b0;
    end
  end

  assign mem_addr = pc;
  assign busy     = (state == FETCH) || (state == LOAD) || (state == ISSUE) || (state == WAIT_DONE);
  assign halted   = (state == HALT);

  register #(.W(INSTR_W)) u_instr (
    .clk   (clk),
    .reset (reset),
    .en    (state == LOAD),
    .d     (mem_data),
    .q     (instruction)
  );

endmodule

// File: tb/tb_bitty_fetch.sv
// tb/tb_bitty_fetch.sv - directed bench for bitty_fetch with memory and core models
module tb_bitty_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_addr = '0;
  logic [7:0]  end_addr = '0;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data = '0;
  logic [15:0] instruction;
  logic [15:0] retired;
  logic        run, done, busy, halted, err;
  logic        core_done = 1'b0;
  logic        spur_done = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int core_delay = 0;
  int core_cnt = 0;
  int rbase, dbase, t0, halt_cyc;
  int          run_cycle[$];
  logic [7:0]  run_addr[$];
  logic [15:0] run_instr[$];
  logic [15:0] done_instr[$];

  assign done = core_done | spur_done;

  bitty_fetch #(.ADDR_W(8), .TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_addr  (start_addr),
    .end_addr    (end_addr),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .instruction (instruction),
    .run         (run),
    .done        (done),
    .busy        (busy),
    .halted      (halted),
    .err         (err),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memword(input logic [7:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    mem_data <= memword(mem_addr);
  end

  // core model: done arrives core_delay cycles after run; 0 means never
  initial forever begin
    @(posedge clk);
    #2;
    core_done = 1'b0;
    if (reset) begin
      core_cnt = 0;
    end else begin
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_done = 1'b1;
          done_instr.push_back(instruction);
        end
      end
      if (run) begin
        run_cycle.push_back(cyc);
        run_addr.push_back(mem_addr);
        run_instr.push_back(instruction);
        if (core_delay > 0) core_cnt = core_delay;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [7:0] s, input logic [7:0] e, input int dly);
    core_delay = dly;
    start_addr = s;
    end_addr   = e;
    start      = 1'b1;
    rbase      = run_addr.size();
    dbase      = done_instr.size();
    t0         = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    halt_cyc = cyc;
    check(tag, halted, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_run"}, run, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_retired"}, retired, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_instr"}, instruction, 0);
  endtask

  initial begin
    tick();
    tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // four-word program, done two cycles after run
    launch(8'd0, 8'd3, 2);
    wait_halt("p0_halt", 100);
    check("p0_runs", run_addr.size() - rbase, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("p0_instr%0d", i), run_instr[rbase+i], memword(8'(i)));
      check($sformatf("p0_hold%0d", i), done_instr[dbase+i], memword(8'(i)));
    end
    check("p0_retired", retired, 4);
    check("p0_err", err, 0);

    // minimum 4-cycle period and first-run latency
    launch(8'd10, 8'd11, 1);
    wait_halt("per_halt", 50);
    check("per_first_run", run_cycle[rbase] - t0, 3);
    check("per_period", run_cycle[rbase+1] - run_cycle[rbase], 4);

    // single instruction, done in first WAIT_DONE cycle
    launch(8'd5, 8'd5, 1);
    wait_halt("one_halt", 50);
    check("one_runs", run_addr.size() - rbase, 1);
    check("one_addr", run_addr[rbase], 8'd5);
    check("one_halt_cyc", halt_cyc - t0, 5);
    check("one_retired", retired, 1);

    // wrap through the top of the address space
    launch(8'hFE, 8'h01, 2);
    wait_halt("wrap_halt", 100);
    check("wrap_runs", run_addr.size() - rbase, 4);
    check("wrap_a0", run_addr[rbase], 8'hFE);
    check("wrap_a1", run_addr[rbase+1], 8'hFF);
    check("wrap_a2", run_addr[rbase+2], 8'h00);
    check("wrap_a3", run_addr[rbase+3], 8'h01);
    check("wrap_retired", retired, 4);

    // core never answers: watchdog abort
    launch(8'd20, 8'd22, 0);
    wait_halt("to_halt", 50);
    check("to_halt_cyc", halt_cyc - t0, 12);
    check("to_err", err, 1);
    check("to_retired", retired, 0);
    check("to_runs", run_addr.size() - rbase, 1);
    launch(8'd30, 8'd30, 2);
    check("to_err_clr", err, 0);
    wait_halt("to_rerun_halt", 50);
    check("to_rerun_retired", retired, 1);

    // spurious done during LOAD
    launch(8'd40, 8'd41, 2);
    tick();
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    wait_halt("sp_halt", 100);
    check("sp_err", err, 1);
    check("sp_retired", retired, 2);
    check("sp_runs", run_addr.size() - rbase, 2);
    check("sp_a1", run_addr[rbase+1], 8'd41);

    // reset during WAIT_DONE of the second instruction
    launch(8'd6, 8'd8, 3);
    begin
      int n = 0;
      while ((run_addr.size() - rbase) < 2 && n < 50) begin
        tick();
        n++;
      end
    end
    check("mr_second_run", run_addr.size() - rbase, 2);
    reset = 1'b1;
    tick();
    check_reset_outputs("mr");
    reset = 1'b0;
    launch(8'd6, 8'd8, 2);
    check("mr_fetch_addr", mem_addr, 8'd6);
    wait_halt("mr_halt", 100);
    check("mr_first_addr", run_addr[rbase], 8'd6);
    check("mr_retired", retired, 3);
    check("mr_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
